// File: rtl/seq_match_pkg.sv
// seq_match_pkg
// Shared types for the programmable sequence detector:
//   state_t      - FSM state encoding (IDLE / RUN / DONE)
//   step_entry_t - one pattern-table entry (compare mask, expected value,
//                  wait-on-miss flag)
//   idx_w()      - step-index width derived from the table depth
// Entries are stored at SM_MAX_IN_W bits so one package serves every IN_W
// instance; a detector with IN_W <= SM_MAX_IN_W zero-fills the upper bits.
package seq_match_pkg;

  localparam int SM_MAX_IN_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 'wait' is a reserved word, so the wait-on-miss flag is wait_miss
  typedef struct packed {
    logic [SM_MAX_IN_W-1:0] mask;
    logic [SM_MAX_IN_W-1:0] value;
    logic                   wait_miss;
  } step_entry_t;

  // Width of an index into a table of 'depth' entries (at least 1 bit)
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/seq_match_table.sv
// seq_match_table
// Pattern register file for seq_match_fsm: DEPTH entries of step_entry_t.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset (clears all entries)
//   wr_en             - write strobe (any busy gating is done by the parent)
//   wr_addr           - entry to write
//   wr_mask/value/wait- entry contents to write
//   rd_addr           - entry to read (combinational)
//   rd_mask/value/wait- contents of entry rd_addr
module seq_match_table
  import seq_match_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int IDX_W = idx_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_addr,
  input  logic [SM_MAX_IN_W-1:0] wr_mask,
  input  logic [SM_MAX_IN_W-1:0] wr_value,
  input  logic                   wr_wait,
  input  logic [IDX_W-1:0]       rd_addr,
  output logic [SM_MAX_IN_W-1:0] rd_mask,
  output logic [SM_MAX_IN_W-1:0] rd_value,
  output logic                   rd_wait
);

  step_entry_t entries [DEPTH];
  step_entry_t wr_entry;
  step_entry_t rd_entry;

  // Pack the write port fields into one entry
  always_comb begin
    wr_entry           = '0;
    wr_entry.mask      = wr_mask;
    wr_entry.value     = wr_value;
    wr_entry.wait_miss = wr_wait;
  end

  // Storage: reset leaves every entry as an unconditional, restart-on-miss step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en) begin
      entries[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = entries[rd_addr];
  assign rd_mask  = rd_entry.mask;
  assign rd_value = rd_entry.value;
  assign rd_wait  = rd_entry.wait_miss;

endmodule

// File: rtl/seq_match_fsm.sv
// seq_match_fsm
// Run-time programmable input-sequence detector. A table of up to DEPTH
// masked-compare steps is walked one valid beat at a time; each step either
// restarts on a miss or waits on a miss (with optional miss-count timeout).
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   in_vec, in_valid      - monitored inputs, sampled only when in_valid=1
//   cfg_we, cfg_addr,
//   cfg_mask, cfg_value,
//   cfg_wait              - pattern entry write (ignored while busy)
//   cfg_len_we, cfg_len,
//   cfg_timeout           - active length / wait timeout load (ignored while busy)
//   arm, clear            - start detection / return to IDLE (clear wins)
//   step                  - current step index
//   busy                  - 1 in RUN
//   match, fail           - one-cycle pulses: sequence complete / restart
//   done                  - level, 1 in DONE
// IN_W must not exceed seq_match_pkg::SM_MAX_IN_W.
module seq_match_fsm
  import seq_match_pkg::*;
#(
  parameter  int IN_W  = 4,
  parameter  int DEPTH = 16,
  parameter  int TO_W  = 8,
  localparam int IDX_W = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_vec,
  input  logic             in_valid,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [IN_W-1:0]  cfg_mask,
  input  logic [IN_W-1:0]  cfg_value,
  input  logic             cfg_wait,
  input  logic             cfg_len_we,
  input  logic [IDX_W:0]   cfg_len,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             arm,
  input  logic             clear,
  output logic [IDX_W-1:0] step,
  output logic             busy,
  output logic             match,
  output logic             fail,
  output logic             done
);

  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(DEPTH);

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_W-1:0]       step_nxt;
  logic [TO_W-1:0]        wait_cnt;
  logic [TO_W-1:0]        cnt_nxt;
  logic [TO_W-1:0]        cnt_sat;
  logic [TO_W-1:0]        timeout_q;
  logic [IDX_W:0]         len_q;
  logic [IDX_W:0]         len_clamped;
  logic                   match_nxt;
  logic                   fail_nxt;
  logic                   busy_nxt;
  logic                   done_nxt;
  logic [SM_MAX_IN_W-1:0] vec_ext;
  logic [SM_MAX_IN_W-1:0] mask_ext;
  logic [SM_MAX_IN_W-1:0] value_ext;
  logic [SM_MAX_IN_W-1:0] rd_mask;
  logic [SM_MAX_IN_W-1:0] rd_value;
  logic                   rd_wait;
  logic                   hit;
  logic                   last_step;
  logic                   timed_out;
  logic                   arm_ok;
  logic                   cfg_open;

  // Widen the input and write data to the table's storage width; the upper
  // mask bits are always zero, so the extra bits never affect a compare
  always_comb begin
    vec_ext               = '0;
    mask_ext              = '0;
    value_ext             = '0;
    vec_ext[IN_W-1:0]     = in_vec;
    mask_ext[IN_W-1:0]    = cfg_mask;
    value_ext[IN_W-1:0]   = cfg_value;
  end

  assign cfg_open = ~busy;

  seq_match_table #(
    .DEPTH (DEPTH)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cfg_we & cfg_open),
    .wr_addr  (cfg_addr),
    .wr_mask  (mask_ext),
    .wr_value (value_ext),
    .wr_wait  (cfg_wait),
    .rd_addr  (step),
    .rd_mask  (rd_mask),
    .rd_value (rd_value),
    .rd_wait  (rd_wait)
  );

  // Over-long lengths are clamped so the final step always exists in the table
  assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  // Length and timeout registers, writable only outside RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      timeout_q <= '0;
    end else if (cfg_len_we && cfg_open) begin
      len_q     <= len_clamped;
      timeout_q <= cfg_timeout;
    end
  end

  // Step evaluation terms shared by the next-state and output logic
  assign hit       = ((vec_ext ^ rd_value) & rd_mask) == '0;
  assign last_step = ({1'b0, step} + (IDX_W+1)'(1)) == len_q;
  assign cnt_sat   = (wait_cnt == '1) ? wait_cnt : wait_cnt + TO_W'(1);
  assign timed_out = (timeout_q != '0) && (cnt_sat >= timeout_q);
  assign arm_ok    = arm && (len_q != '0);

  // State register plus every registered output and the wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      step     <= '0;
      wait_cnt <= '0;
      match    <= 1'b0;
      fail     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      step     <= step_nxt;
      wait_cnt <= cnt_nxt;
      match    <= match_nxt;
      fail     <= fail_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state logic; an arm with no programmed length is ignored
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (arm_ok) state_nxt = RUN;
        RUN:     if (in_valid && hit && last_step) state_nxt = DONE;
        DONE:    if (arm_ok) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and the wait counter. A restart
  // only rewinds to step 0; the beat that missed is not re-tried there.
  always_comb begin
    step_nxt  = step;
    cnt_nxt   = wait_cnt;
    match_nxt = 1'b0;
    fail_nxt  = 1'b0;
    if (clear) begin
      step_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm_ok) begin
            step_nxt = '0;
            cnt_nxt  = '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (hit) begin
              cnt_nxt = '0;
              if (last_step) begin
                match_nxt = 1'b1;
              end else begin
                step_nxt = step + IDX_W'(1);
              end
            end else if (!rd_wait || timed_out) begin
              step_nxt = '0;
              cnt_nxt  = '0;
              fail_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt_sat;
            end
          end
        end
        default: begin
          step_nxt = '0;
          cnt_nxt  = '0;
        end
      endcase
    end
    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_seq_match_fsm.sv
// tb_seq_match_fsm
// Directed bench for seq_match_fsm at default parameters. Each stimulus beat
// pushes its hand-computed expected outputs {step, match, fail, busy, done}
// into a queue; a monitor on the falling edge pops and compares them.
module tb_seq_match_fsm;

  logic       clk;
  logic       reset;
  logic [3:0] in_vec;
  logic       in_valid;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [3:0] cfg_mask;
  logic [3:0] cfg_value;
  logic       cfg_wait;
  logic       cfg_len_we;
  logic [4:0] cfg_len;
  logic [7:0] cfg_timeout;
  logic       arm;
  logic       clear;
  logic [3:0] step;
  logic       busy;
  logic       match;
  logic       fail;
  logic       done;

  int         total;
  int         bad;
  logic [7:0] exp_q [$];
  string      name_q [$];
  logic [7:0] mon_exp;
  string      mon_name;
  logic [3:0] pm [12];
  logic [3:0] pv [12];

  seq_match_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .in_vec      (in_vec),
    .in_valid    (in_valid),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_mask    (cfg_mask),
    .cfg_value   (cfg_value),
    .cfg_wait    (cfg_wait),
    .cfg_len_we  (cfg_len_we),
    .cfg_len     (cfg_len),
    .cfg_timeout (cfg_timeout),
    .arm         (arm),
    .clear       (clear),
    .step        (step),
    .busy        (busy),
    .match       (match),
    .fail        (fail),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare packed {step, match, fail, busy, done} against the required value
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got step=%0d match=%b fail=%b busy=%b done=%b, want step=%0d match=%b fail=%b busy=%b done=%b",
               name, act[7:4], act[3], act[2], act[1], act[0],
               req[7:4], req[3], req[2], req[1], req[0]);
    end
  endtask

  // Drive one clock of control inputs and queue the outputs expected after it
  task automatic applyStimulus(input logic [3:0] vec, input logic valid, input logic a,
                               input logic c, input logic [3:0] es, input logic em,
                               input logic ef, input logic eb, input logic ed,
                               input string name);
    in_vec   = vec;
    in_valid = valid;
    arm      = a;
    clear    = c;
    @(posedge clk);
    #1;
    exp_q.push_back({es, em, ef, eb, ed});
    name_q.push_back(name);
    in_valid = 1'b0;
    arm      = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic programEntry(input logic [3:0] addr, input logic [3:0] m,
                              input logic [3:0] v, input logic w);
    cfg_addr  = addr;
    cfg_mask  = m;
    cfg_value = v;
    cfg_wait  = w;
    cfg_we    = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic loadLen(input logic [4:0] len, input logic [7:0] to);
    cfg_len     = len;
    cfg_timeout = to;
    cfg_len_we  = 1'b1;
    @(posedge clk);
    #1;
    cfg_len_we = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      checkOutput(mon_name, {step, match, fail, busy, done}, mon_exp);
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    in_vec      = '0;
    in_valid    = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_mask    = '0;
    cfg_value   = '0;
    cfg_wait    = 1'b0;
    cfg_len_we  = 1'b0;
    cfg_len     = '0;
    cfg_timeout = '0;
    arm         = 1'b0;
    clear       = 1'b0;

    pm[0] = 4'b0100; pv[0] = 4'b0100;
    pm[1] = 4'b1001; pv[1] = 4'b1001;
    pm[2] = 4'b0100; pv[2] = 4'b0000;
    pm[3] = 4'b0011; pv[3] = 4'b0010;
    pm[4] = 4'b1000; pv[4] = 4'b1000;
    pm[5] = 4'b0110; pv[5] = 4'b0100;
    pm[6] = 4'b0001; pv[6] = 4'b0001;
    pm[7] = 4'b1111; pv[7] = 4'b1010;
    pm[8] = 4'b0010; pv[8] = 4'b0010;
    pm[9] = 4'b1100; pv[9] = 4'b0100;
    pm[10] = 4'b0101; pv[10] = 4'b0001;
    pm[11] = 4'b0000; pv[11] = 4'b0000;

    #1 reset = 1'b0;
    #1 checkOutput("reset_state", {step, match, fail, busy, done}, 8'h00);
    #10 reset = 1'b1;

    // Legacy 12-step sequence, unchecked bits carry garbage
    for (int i = 0; i < 12; i++) programEntry(4'(i), pm[i], pv[i], 1'b0);
    loadLen(5'd12, 8'd0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "arm12");
    for (int i = 0; i < 12; i++) begin
      if (i < 11)
        applyStimulus((pv[i] & pm[i]) | (~pm[i] & 4'b1010), 1'b1, 1'b0, 1'b0,
                      4'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, "seq12_step");
      else
        applyStimulus((pv[i] & pm[i]) | (~pm[i] & 4'b1010), 1'b1, 1'b0, 1'b0,
                      4'd11, 1'b1, 1'b0, 1'b0, 1'b1, "seq12_match");
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1, "seq12_done_hold");

    // Restart on miss, no re-evaluation against step 0 in the same beat
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_from_done");
    programEntry(4'd0, 4'b1111, 4'b0001, 1'b0);
    programEntry(4'd1, 4'b1111, 4'b0010, 1'b0);
    programEntry(4'd2, 4'b1111, 4'b0100, 1'b0);
    loadLen(5'd3, 8'd0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "arm3");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "len3_s0");
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, "miss_restart");
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, "eval_step0_only");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "len3_s0_again");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, "no_same_cycle_reeval");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "len3_s0_third");
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, "len3_s1");
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, "len3_match");

    // Wait step with timeout 3
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "clear2");
    programEntry(4'd1, 4'b1111, 4'b0010, 1'b1);
    loadLen(5'd3, 8'd3);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "arm_to3");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "to3_s0");
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "wait_miss1");
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "wait_miss2");
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, "timeout_fail");

    // Wait step with no timeout: counter saturates, never fails
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "clear3");
    loadLen(5'd3, 8'd0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "arm_to0");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "to0_s0");
    for (int i = 0; i < 300; i++)
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "no_timeout");
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, "to0_s1");
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, "to0_match");

    // in_valid low holds everything; re-arm straight from DONE
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "rearm_from_done");
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "iv_s0");
    for (int i = 0; i < 3; i++)
      applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "valid_low");
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, "iv_s1");
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, "valid_low2");
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, "iv_match");
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, "done_hold");

    // Config writes in RUN are dropped
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "arm_cfg");
    cfg_addr    = 4'd0;
    cfg_mask    = 4'b1111;
    cfg_value   = 4'b1000;
    cfg_wait    = 1'b0;
    cfg_we      = 1'b1;
    cfg_len     = 5'd1;
    cfg_timeout = 8'd0;
    cfg_len_we  = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "cfg_in_run");
    cfg_we     = 1'b0;
    cfg_len_we = 1'b0;
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "entry_and_len_kept");
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "clear4");
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "arm_readback");
    applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, "entry_kept_after_clear");
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "clear5");
    loadLen(5'd0, 8'd0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "arm_len0");

    // Length above DEPTH clamps to 16; all-zero masks advance unconditionally
    for (int i = 0; i < 16; i++) programEntry(4'(i), 4'b0000, 4'b0000, 1'b0);
    loadLen(5'd31, 8'd0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "arm_clamp");
    for (int i = 0; i < 16; i++) begin
      if (i < 15)
        applyStimulus(4'(i * 7), 1'b1, 1'b0, 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, "clamp_step");
      else
        applyStimulus(4'(i * 7), 1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, "clamp_match");
    end

    // Asynchronous reset mid-RUN at step 5
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "arm_rst");
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, "rst_walk");
    @(negedge clk);
    #1 reset = 1'b0;
    #1 checkOutput("async_reset", {step, match, fail, busy, done}, 8'h00);
    #1 reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "arm_after_reset");

    // clear beats arm in DONE
    loadLen(5'd1, 8'd0);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "arm_len1");
    applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, "len1_match");
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "clear_arm_together");
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_after");

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL queue_drained: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_match_fsm.md
Name: seq_match_fsm

Overview:
Parametrised, run-time-programmable input-sequence detector. It is the next generation of the team's fixed 13-state hard-coded detector. A pattern table of up to DEPTH steps is programmed at run time. Each step holds a masked compare over IN_W inputs and either restarts on a miss or waits on a miss, with an optional timeout. It sits between the input-sampling logic and the controller, and reports the current step, match/fail pulses and a done level.

Parameters:
IN_W, 4, width of the monitored input vector (in_vec[0]=i1 ... in_vec[3]=i4 at default)
DEPTH, 16, maximum number of pattern steps (power of 2, ≥2)
IDX_W, $clog2(DEPTH), step-index width (derived, not overridden)
TO_W, 8, width of the wait-step timeout counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset; 0 = reset asserted
in_vec  in  IN_W  monitored inputs
in_valid  in  1  in_vec is sampled only when 1
cfg_we  in  1  write pattern entry at cfg_addr
cfg_addr  in  IDX_W  pattern entry index
cfg_mask  in  IN_W  compare mask (1 = bit is checked)
cfg_value  in  IN_W  expected value of the checked bits
cfg_wait  in  1  1 = stay on this step on a miss; 0 = restart on a miss
cfg_len_we  in  1  load cfg_len
cfg_len  in  IDX_W+1  number of active steps, 0..DEPTH
cfg_timeout  in  TO_W  wait-step miss limit, loaded with cfg_len_we; 0 = no timeout
arm  in  1  start detection
clear  in  1  return to IDLE
step  out  IDX_W  current step index
busy  out  1  1 in RUN
match  out  1  one-cycle pulse on completion of the final step
fail  out  1  one-cycle pulse on a restart
done  out  1  level; 1 in DONE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; step=0; busy=0; match=0; fail=0; done=0; len=0; timeout=0; wait counter=0; all table entries cleared (mask=0, value=0, wait=0).
- States: IDLE, RUN, DONE, encoded in the package enum.
- IDLE:
  - arm with len≠0 -> RUN, step=0, wait counter=0.
  - arm with len=0 is ignored; state stays IDLE.
- RUN, only on cycles with in_valid=1:
  - hit = ((in_vec ^ value[step]) & mask[step]) == 0.
  - mask=0 is an unconditional advance on any valid beat.
  - hit, step<len-1 -> step+1, wait counter=0.
  - hit, step=len-1 -> DONE; match=1 for one cycle; step holds the last index.
  - miss, wait=0 -> step=0, fail=1 for one cycle, state stays RUN. There is no same-cycle re-evaluation against step 0.
  - miss, wait=1 -> step holds and the wait counter increments. When timeout≠0 and the counter reaches timeout, the result is step=0, fail pulse, counter=0. The counter saturates and never wraps.
  - in_valid=0 -> everything holds; the wait counter does not count.
- DONE: done=1 and step holds.
  - arm -> RUN, step=0; done drops in the same edge.
  - clear -> IDLE.
- clear in any state -> IDLE, step=0, counter=0, with no fail pulse.
- clear and arm in the same cycle: clear wins.
- All outputs are registered. Latency from the sampled valid beat to the step/match/fail update is 1 clock.
- Configuration writes (cfg_we, cfg_len_we) take effect only when busy=0 and are silently dropped in RUN.
- cfg_len>DEPTH is clamped to DEPTH on load.
- reset=0 mid-RUN aborts immediately with no pulse.

Decomposition:
- Package seq_match_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - step_entry_t struct {mask[IN_W], value[IN_W], wait}.
  - Localparam helpers for IDX_W.
- Sub-module seq_match_table holds the pattern register file:
  - DEPTH×step_entry_t.
  - Write port with busy gating done in the parent.
  - Combinational read at step.
  - Asynchronous clear on reset.
- The parent holds the FSM, step counter and wait/timeout counter.

Test Plan:
- Program the legacy 12-step sequence, e.g. step0 mask=0100/value=0100, step1 mask=1001/value=1001, step2 mask=0100/value=0000, with len=12. Arm and drive the matching beats -> step goes 0..11, match pulses once on the 12th beat, done=1.
- len=3, all wait=0. Drive a good beat then a bad beat at step1 -> fail pulses 1 cycle, step=0. The next beat is evaluated against step0 only.
- Step1 wait=1, timeout=3. Drive 3 missing valid beats -> step stays 1 for 2 beats, then fail, step=0. Repeat with timeout=0 and 300 misses -> no fail, and step stays 1.
- Toggle in_valid=0 mid-sequence with garbage on in_vec -> step, match and fail are unchanged.
- cfg_we during RUN -> the entry is unchanged when read back after clear. Arm with len=0 -> busy stays 0.
- Assert reset=0 asynchronously mid-RUN at step 5 -> outputs are 0 immediately, before the next clk edge. After release, arm is ignored because len=0.
- clear and arm asserted together in DONE -> IDLE, done=0.
